// File: rtl/de0qsys_hex_pkg.sv
// Shared constants for the multiplexed seven-segment controller: register map,
// CTRL field positions and the hex segment font.
package de0qsys_hex_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_DP     = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_EN_BIT       = 0;
  localparam int CTRL_BLINK_EN_BIT = 1;
  localparam int CTRL_BLANK_LSB    = 8;
  localparam int CTRL_BLINK_LSB    = 16;

  localparam logic [31:0] CTRL_RESET = 32'h0000_0001;
  // Only EN, BLINK_EN and the two 8-bit masks are stored; everything else reads 0.
  localparam logic [31:0] CTRL_WMASK = 32'h00FF_FF03;

  // Active-high font, bit order {dp,g,f,e,d,c,b,a}; entry 15 first.
  localparam logic [15:0][7:0] SEG_FONT = {
    8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
    8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

  // Font lookup with the decimal point OR'd in as bit 7.
  function automatic logic [7:0] seg_lookup(input logic [3:0] value, input logic dp);
    return SEG_FONT[value] | {dp, 7'b000_0000};
  endfunction

endpackage

// File: rtl/de0qsys_hex_scan_if.sv
// Avalon-MM s1 slave bus of the hex display controller.
interface de0qsys_hex_scan_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/hex7seg_decode.sv
// Combinational hex-to-segment decoder, active-high {dp,g,f,e,d,c,b,a}.
module hex7seg_decode
  import de0qsys_hex_pkg::*;
(
  input  logic [3:0] value_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  // Font table lookup plus decimal point.
  always_comb begin
    seg_o = seg_lookup(value_i, dp_i);
  end

endmodule

// File: rtl/de0qsys_hex_scan.sv
// Time-multiplexed seven-segment display controller on an Avalon-MM slave.
// Holds one hex nibble per digit, scans digits one slot at a time and supports
// per-digit decimal point, blanking and blinking.
module de0qsys_hex_scan
  import de0qsys_hex_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  de0qsys_hex_scan_if.slave     s1,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] dig_sel
);

  localparam int DW      = 4 * NUM_DIGITS;
  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [7:0]            SEG_OFF = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                : {NUM_DIGITS{1'b0}};

  logic [DW-1:0]         data_q;
  logic [31:0]           ctrl_q;
  logic [NUM_DIGITS-1:0] dp_q;
  logic [SCAN_W-1:0]     scan_q, scan_d;
  logic [2:0]            idx_q, idx_d;
  logic [FRAME_W-1:0]    frame_q, frame_d;
  logic                  phase_q, phase_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;

  logic                  wr_s, en_s, blink_en_s, dark_s, dp_s;
  logic [7:0]            blank_s, blink_s, dec_seg_s;
  logic [3:0]            val_s;
  logic [NUM_DIGITS-1:0] onehot_s;
  logic [31:0]           rdata_s;
  logic                  unused_s;

  assign wr_s       = s1.chipselect & ~s1.write_n;
  assign en_s       = ctrl_q[CTRL_EN_BIT];
  assign blink_en_s = ctrl_q[CTRL_BLINK_EN_BIT];
  assign blank_s    = ctrl_q[CTRL_BLANK_LSB +: 8];
  assign blink_s    = ctrl_q[CTRL_BLINK_LSB +: 8];
  assign unused_s   = ^s1.writedata;

  // Register file: DATA, CTRL and DP are written by the bus; STATUS writes are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      ctrl_q <= CTRL_RESET;
      dp_q   <= '0;
    end else if (wr_s) begin
      case (s1.address)
        ADDR_DATA: data_q <= s1.writedata[DW-1:0];
        ADDR_CTRL: ctrl_q <= s1.writedata & CTRL_WMASK;
        ADDR_DP:   dp_q   <= s1.writedata[NUM_DIGITS-1:0];
        default:   data_q <= data_q;
      endcase
    end
  end

  // Next state of the slot / digit / frame / blink-phase counter chain; all held at 0 while disabled.
  always_comb begin
    scan_d  = scan_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    phase_d = phase_q;
    if (!en_s) begin
      scan_d  = '0;
      idx_d   = 3'd0;
      frame_d = '0;
      phase_d = 1'b0;
    end else if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_d = '0;
      if (idx_q == 3'(NUM_DIGITS - 1)) begin
        idx_d = 3'd0;
        if (frame_q == FRAME_W'(BLINK_FRAMES - 1)) begin
          frame_d = '0;
          phase_d = ~phase_q;
        end else begin
          frame_d = frame_q + FRAME_W'(1);
        end
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end else begin
      scan_d = scan_q + SCAN_W'(1);
    end
  end

  // Counter chain registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_q  <= '0;
      idx_q   <= 3'd0;
      frame_q <= '0;
      phase_q <= 1'b0;
    end else begin
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      phase_q <= phase_d;
    end
  end

  // Select the current digit's nibble, dp bit and one-hot enable with an AND-OR mux.
  always_comb begin
    val_s    = 4'h0;
    dp_s     = 1'b0;
    onehot_s = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      onehot_s[i] = (idx_q == 3'(i));
      val_s       = val_s | (data_q[4*i +: 4] & {4{onehot_s[i]}});
      dp_s        = dp_s | (dp_q[i] & onehot_s[i]);
    end
  end

  hex7seg_decode u_decode (
    .value_i (val_s),
    .dp_i    (dp_s),
    .seg_o   (dec_seg_s)
  );

  // Darken the digit when blanked, blinking in its off phase, or the display is disabled; apply pin polarity.
  always_comb begin
    dark_s = blank_s[idx_q] | (blink_en_s & blink_s[idx_q] & phase_q) | ~en_s;
    if (dark_s) begin
      seg_d = SEG_OFF;
      dig_d = DIG_OFF;
    end else if (ACTIVE_LOW != 0) begin
      seg_d = ~dec_seg_s;
      dig_d = ~onehot_s;
    end else begin
      seg_d = dec_seg_s;
      dig_d = onehot_s;
    end
  end

  // Registered pin drivers, inactive during reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_q <= SEG_OFF;
      dig_q <= DIG_OFF;
    end else begin
      seg_q <= seg_d;
      dig_q <= dig_d;
    end
  end

  assign seg     = seg_q;
  assign dig_sel = dig_q;

  // Zero-latency, side-effect-free register readback, zero-extended.
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (s1.address)
      ADDR_DATA:   rdata_s[DW-1:0] = data_q;
      ADDR_CTRL:   rdata_s = ctrl_q;
      ADDR_DP:     rdata_s[NUM_DIGITS-1:0] = dp_q;
      ADDR_STATUS: begin
        rdata_s[2:0] = idx_q;
        rdata_s[8]   = phase_q;
      end
      default:     rdata_s = 32'h0000_0000;
    endcase
  end

  assign s1.readdata = rdata_s;

endmodule
